atm_vault: RTL and testbench
============================

# atm_vault

Cash vault and account ledger that sits behind the ATM front-end controller and answers its denomination strobes. It detects rising edges on the six withdraw/deposit lines and checks withdrawals against the account balance and the note inventory. Accepted withdrawals are dispensed as one pulse per 50 000 note; deposits are credited. Every request ends in exactly one `done` or `denied` pulse.

## Interface
- `BAL_W`, 16: balance width, in 50 000 units.
- `CASH_W`, 12: note-inventory width, in notes.
- `INIT_BALANCE`, 20: balance after reset.
- `INIT_CASH`, 100: notes in the vault after reset.
- `LIMIT_UNITS`, 8: cap on cumulative withdrawal since reset; used only with `ATM_VAULT_LIMIT_EN`.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `W_50000`, `W_100000`, `W_200000`  in  1 each  withdraw level strobes from the ATM controller.
- `D_50000`, `D_100000`, `D_200000`  in  1 each  deposit level strobes.
- `busy`  out  1  high from the first cycle after request capture until the cycle after `done`/`denied`.
- `dispense`  out  1  one-cycle pulse per note released.
- `done`  out  1  one-cycle pulse: request completed.
- `denied`  out  1  one-cycle pulse: request refused.
- `overrun`  out  1  sticky: an edge arrived while busy.
- `balance`  out  BAL_W  current balance.
- `cash`  out  CASH_W  current inventory.

## Operation
- Denomination unit counts: 50 000 → 1, 100 000 → 2, 200 000 → 4.
- Edge detect:
  - One registered copy of each strobe is kept; all copies reset to 0.
  - An edge is `in & ~prev`.
  - A strobe held high through reset release therefore counts once.
- Priority when several edges share a cycle: W_200000 > W_100000 > W_50000 > D_200000 > D_100000 > D_50000. Losers are dropped and `overrun` is set.
- Edges arriving outside IDLE are dropped and set `overrun`. `overrun` clears only on reset.
- States are IDLE, CHECK, DISP_ON, DISP_GAP, DONE, DENY.
  - IDLE: on a captured edge, latch direction and k, then go to CHECK.
  - CHECK, withdraw: refused if `balance < k`, or `cash < k`, or (with the macro) `withdrawn + k > LIMIT_UNITS`; refusal goes to DENY. Otherwise `balance -= k`, `cash -= k`, note counter = k, and go to DISP_ON.
  - CHECK, deposit: if `balance + k` or `cash + k` overflows its width, go to DENY. Otherwise add k to both and go to DONE.
  - DISP_ON: `dispense=1`, decrement the counter. Go to DONE if the counter is now 0, else to DISP_GAP.
  - DISP_GAP: `dispense=0`, go to DISP_ON.
  - DONE: `done=1` for one cycle, then go to IDLE.
  - DENY: `denied=1` for one cycle, then go to IDLE. Balance and cash are unchanged.
- Arithmetic is unsigned with no wrap-around; overflow is prevented by the deny rule.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`, `dispense`, `done`, `denied`, `overrun` = 0.
  - `balance` = INIT_BALANCE; `cash` = INIT_CASH; withdrawn counter = 0.
- Cycle numbering: cycle 0 is the CHECK cycle, the first cycle after the edge is sampled.
- Withdraw of k notes:
  - `dispense` is high in cycles 1, 3, …, 2k−1.
  - `done` is high in cycle 2k.
- Deposit: `done` is high in cycle 1.
- Deny: `denied` is high in cycle 1.
- `balance` and `cash` update at the end of cycle 0.
- `busy` is high in cycle 0 through the `done`/`denied` cycle inclusive.
- Back-to-back: an edge in the cycle after `done` (state IDLE) is accepted.
- Reset mid-dispense: the next cycle is IDLE, there are no further pulses, and all counters return to their INIT values.

## Configuration
- `ATM_VAULT_LIMIT_EN` defined:
  - A `BAL_W`-wide withdrawn counter is added; it accumulates the k of every accepted withdrawal.
  - A withdrawal is denied when `withdrawn + k > LIMIT_UNITS`.
  - The counter clears on reset.
- Not defined: no counter and no limit check; `LIMIT_UNITS` is ignored.

## Structure
- Shared package `atm_pkg` holds:
  - the state enum,
  - denomination unit constants (1/2/4),
  - the direction type (WITHDRAW/DEPOSIT).
- The ATM front-end controller uses the same denomination constants from this package.
- One sub-module, `atm_vault_req`: the strobe registers, edge detect, and priority encoder. It outputs `req_valid`, `req_dir`, `req_units`, and `req_collide`.
- The FSM, counters and ledger live in `atm_vault`.

## Test plan
- Reset, then a W_100000 rise → `dispense` in cycles 1 and 3, `done` in cycle 4; balance 20→18, cash 100→98.
- A D_200000 rise → `done` in cycle 1, no `dispense`; balance 20→24, cash 100→104.
- Balance drained to 3, then a W_200000 rise → `denied` in cycle 1, no `dispense`; balance stays 3.
- W_50000 and D_50000 rise in the same cycle → withdraw of 1 note processed; `overrun`=1 and stays set.
- Reset asserted after the 2nd `dispense` of a W_200000 → no further pulses; balance=20, cash=100, `busy`=0.
- With `ATM_VAULT_LIMIT_EN` and LIMIT_UNITS=8: W_200000, W_200000, then W_50000 → the first two end in `done`, the third in `denied`; balance ends at 12.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared ATM definitions: vault FSM states, request direction and denomination unit
// counts, used by both the vault and the ATM front-end controller.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DISP_ON  = 3'd2,
        ST_DISP_GAP = 3'd3,
        ST_DONE     = 3'd4,
        ST_DENY     = 3'd5
    } state_t;

    typedef enum logic {
        DIR_WITHDRAW = 1'b0,
        DIR_DEPOSIT  = 1'b1
    } dir_t;

    localparam logic [2:0] UNITS_50000  = 3'd1;
    localparam logic [2:0] UNITS_100000 = 3'd2;
    localparam logic [2:0] UNITS_200000 = 3'd4;

endpackage

// File: rtl/atm_vault_req.sv
// Request front end of the vault: registers the six strobes, detects rising edges
// and picks one winner by fixed priority (withdrawals over deposits, larger notes first).
module atm_vault_req
    import atm_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] i_strobe,     // {W200k, W100k, W50k, D200k, D100k, D50k}
    output logic       req_valid,
    output dir_t       req_dir,
    output logic [2:0] req_units,
    output logic       req_collide
);

    logic [5:0] r_prev;
    logic [5:0] w_edge;

    assign w_edge      = i_strobe & ~r_prev;
    assign req_valid   = (w_edge != 6'd0);
    assign req_collide = ((w_edge & (w_edge - 6'd1)) != 6'd0);

    // Previous-cycle copy of every strobe; cleared so a strobe held through reset counts once.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev <= 6'd0;
        end else begin
            r_prev <= i_strobe;
        end
    end

    // Priority encoder: the highest set edge bit wins.
    always_comb begin
        req_dir   = DIR_WITHDRAW;
        req_units = 3'd0;
        if (w_edge[5]) begin
            req_dir   = DIR_WITHDRAW;
            req_units = UNITS_200000;
        end else if (w_edge[4]) begin
            req_dir   = DIR_WITHDRAW;
            req_units = UNITS_100000;
        end else if (w_edge[3]) begin
            req_dir   = DIR_WITHDRAW;
            req_units = UNITS_50000;
        end else if (w_edge[2]) begin
            req_dir   = DIR_DEPOSIT;
            req_units = UNITS_200000;
        end else if (w_edge[1]) begin
            req_dir   = DIR_DEPOSIT;
            req_units = UNITS_100000;
        end else if (w_edge[0]) begin
            req_dir   = DIR_DEPOSIT;
            req_units = UNITS_50000;
        end else begin
            req_dir   = DIR_WITHDRAW;
            req_units = 3'd0;
        end
    end

endmodule

// File: rtl/atm_vault.sv
// Cash vault and account ledger: checks and executes withdraw/deposit requests and
// pulses dispense once per note. Optional cumulative withdrawal cap: ATM_VAULT_LIMIT_EN.
module atm_vault
    import atm_pkg::*;
#(
    parameter int BAL_W        = 16,
    parameter int CASH_W       = 12,
    parameter int INIT_BALANCE = 20,
    parameter int INIT_CASH    = 100,
    parameter int LIMIT_UNITS  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              W_50000,
    input  logic              W_100000,
    input  logic              W_200000,
    input  logic              D_50000,
    input  logic              D_100000,
    input  logic              D_200000,
    output logic              busy,
    output logic              dispense,
    output logic              done,
    output logic              denied,
    output logic              overrun,
    output logic [BAL_W-1:0]  balance,
    output logic [CASH_W-1:0] cash
);

    logic              w_req_valid;
    dir_t              w_req_dir;
    logic [2:0]        w_req_units;
    logic              w_req_collide;

    state_t            r_state;
    state_t            w_next;
    dir_t              r_dir;
    logic [2:0]        r_units;
    logic [2:0]        r_notes;
    logic [BAL_W-1:0]  r_balance;
    logic [CASH_W-1:0] r_cash;
    logic              r_busy;
    logic              r_dispense;
    logic              r_done;
    logic              r_denied;
    logic              r_overrun;

    logic [BAL_W-1:0]  w_units_bal;
    logic [CASH_W-1:0] w_units_cash;
    logic [BAL_W:0]    w_bal_sum;
    logic [CASH_W:0]   w_cash_sum;
    logic              w_limit_hit;
    logic              w_deny;

    atm_vault_req u_req (
        .clock       (clock),
        .reset       (reset),
        .i_strobe    ({W_200000, W_100000, W_50000, D_200000, D_100000, D_50000}),
        .req_valid   (w_req_valid),
        .req_dir     (w_req_dir),
        .req_units   (w_req_units),
        .req_collide (w_req_collide)
    );

    assign w_units_bal  = BAL_W'(r_units);
    assign w_units_cash = CASH_W'(r_units);
    assign w_bal_sum    = {1'b0, r_balance} + {1'b0, w_units_bal};
    assign w_cash_sum   = {1'b0, r_cash} + {1'b0, w_units_cash};

`ifdef ATM_VAULT_LIMIT_EN
    logic [BAL_W-1:0]  r_withdrawn;
    logic [BAL_W:0]    w_wd_sum;

    assign w_wd_sum    = {1'b0, r_withdrawn} + {1'b0, w_units_bal};
    assign w_limit_hit = (w_wd_sum > (BAL_W+1)'(LIMIT_UNITS));

    // Cumulative withdrawn units since reset, bumped on every accepted withdrawal.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_withdrawn <= {BAL_W{1'b0}};
        end else if (r_state == ST_CHECK && r_dir == DIR_WITHDRAW && !w_deny) begin
            r_withdrawn <= w_wd_sum[BAL_W-1:0];
        end else begin
            r_withdrawn <= r_withdrawn;
        end
    end
`else
    assign w_limit_hit = 1'b0;
`endif

    // Refusal decision for the latched request; deposits are refused only on overflow.
    always_comb begin
        w_deny = 1'b0;
        if (r_dir == DIR_WITHDRAW) begin
            w_deny = (r_balance < w_units_bal) || (r_cash < w_units_cash) || w_limit_hit;
        end else begin
            w_deny = w_bal_sum[BAL_W] || w_cash_sum[CASH_W];
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:     w_next = w_req_valid ? ST_CHECK : ST_IDLE;
            ST_CHECK: begin
                if (w_deny) begin
                    w_next = ST_DENY;
                end else if (r_dir == DIR_WITHDRAW) begin
                    w_next = ST_DISP_ON;
                end else begin
                    w_next = ST_DONE;
                end
            end
            ST_DISP_ON:  w_next = (r_notes == 3'd1) ? ST_DONE : ST_DISP_GAP;
            ST_DISP_GAP: w_next = ST_DISP_ON;
            ST_DONE:     w_next = ST_IDLE;
            ST_DENY:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // State, ledger and outputs; outputs are decoded from the next state so they are registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_dir      <= DIR_WITHDRAW;
            r_units    <= 3'd0;
            r_notes    <= 3'd0;
            r_balance  <= BAL_W'(INIT_BALANCE);
            r_cash     <= CASH_W'(INIT_CASH);
            r_busy     <= 1'b0;
            r_dispense <= 1'b0;
            r_done     <= 1'b0;
            r_denied   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != ST_IDLE);
            r_dispense <= (w_next == ST_DISP_ON);
            r_done     <= (w_next == ST_DONE);
            r_denied   <= (w_next == ST_DENY);
            if (w_req_valid && (r_state != ST_IDLE || w_req_collide)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        r_dir   <= w_req_dir;
                        r_units <= w_req_units;
                    end
                end
                ST_CHECK: begin
                    if (!w_deny) begin
                        if (r_dir == DIR_WITHDRAW) begin
                            r_balance <= r_balance - w_units_bal;
                            r_cash    <= r_cash - w_units_cash;
                            r_notes   <= r_units;
                        end else begin
                            r_balance <= w_bal_sum[BAL_W-1:0];
                            r_cash    <= w_cash_sum[CASH_W-1:0];
                        end
                    end
                end
                ST_DISP_ON: r_notes <= r_notes - 3'd1;
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign dispense = r_dispense;
    assign done     = r_done;
    assign denied   = r_denied;
    assign overrun  = r_overrun;
    assign balance  = r_balance;
    assign cash     = r_cash;

endmodule

// File: tb/tb_atm_vault.sv
// Scoreboard bench for atm_vault: stimulus pushes expected pulses from a ledger model,
// an independent monitor pops and compares them whenever a pulse appears.
module tb_atm_vault;

    localparam int LIMIT    = 8;
    localparam int BAL_MAX  = 65535;
    localparam int CASH_MAX = 4095;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        W_50000 = 1'b0, W_100000 = 1'b0, W_200000 = 1'b0;
    logic        D_50000 = 1'b0, D_100000 = 1'b0, D_200000 = 1'b0;
    logic        busy, dispense, done, denied, overrun;
    logic [15:0] balance;
    logic [11:0] cash;

    atm_vault dut (
        .clock(clock), .reset(reset),
        .W_50000(W_50000), .W_100000(W_100000), .W_200000(W_200000),
        .D_50000(D_50000), .D_100000(D_100000), .D_200000(D_200000),
        .busy(busy), .dispense(dispense), .done(done), .denied(denied),
        .overrun(overrun), .balance(balance), .cash(cash)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;   // 0 dispense, 1 done, 2 denied
        int cyc;
        int bal;
        int csh;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    int  m_bal, m_cash, m_wd;
    bit  m_ovr;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every observed pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        int  nk;
        int  kind;
        ev_t e;
        nk = int'(dispense === 1'b1) + int'(done === 1'b1) + int'(denied === 1'b1);
        if (nk > 0) begin
            kind = (dispense === 1'b1) ? 0 : ((done === 1'b1) ? 1 : 2);
            chk("pulses_per_cycle", nk, 1);
            if (q.size() == 0) begin
                chk("unexpected_pulse_kind", kind, -1);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", kind, e.kind);
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_balance", balance, e.bal);
                chk("pulse_cash", cash, e.csh);
                chk("pulse_busy", busy, 1);
            end
        end
    end

    task automatic drive(input logic [5:0] p);
        {W_200000, W_100000, W_50000, D_200000, D_100000, D_50000} = p;
    endtask

    function automatic int units_of(input int idx);
        case (idx % 3)
            2:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic wait_drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clock); #1;
            n++;
        end
        if (q.size() != 0) begin
            chk({nm, "_timeout_pending"}, q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(6'd0);
        repeat (2) @(negedge clock);
        q.delete();
        m_bal = 20; m_cash = 100; m_wd = 0; m_ovr = 1'b0;
        reset = 1'b0;
        @(negedge clock); #1;
        chk("rst_busy", busy, 0);
        chk("rst_dispense", dispense, 0);
        chk("rst_done", done, 0);
        chk("rst_denied", denied, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_balance", balance, 20);
        chk("rst_cash", cash, 100);
    endtask

    // One request: pattern pat sampled on the next edge; optional extra edge while busy.
    task automatic do_req(input logic [5:0] pat, input bit inj, input bit settle, output bit was_denied);
        int w, k, c;
        bit wd, dn;
        logic [5:0] ib;
        @(negedge clock);
        c = cyc;
        drive(pat);
        w = -1;
        for (int i = 5; i >= 0; i--) if (pat[i] && w < 0) w = i;
        if ($countones(pat) > 1) m_ovr = 1'b1;
        wd = (w >= 3);
        k  = units_of(w);
        if (wd) begin
            dn = (m_bal < k) || (m_cash < k);
`ifdef ATM_VAULT_LIMIT_EN
            if (m_wd + k > LIMIT) dn = 1'b1;
`endif
        end else begin
            dn = (m_bal + k > BAL_MAX) || (m_cash + k > CASH_MAX);
        end
        was_denied = dn;
        if (dn) begin
            q.push_back('{2, c + 2, m_bal, m_cash});
        end else if (wd) begin
            m_bal -= k; m_cash -= k; m_wd += k;
            for (int i = 0; i < k; i++) q.push_back('{0, c + 2 + 2 * i, m_bal, m_cash});
            q.push_back('{1, c + 1 + 2 * k, m_bal, m_cash});
        end else begin
            m_bal += k; m_cash += k;
            q.push_back('{1, c + 2, m_bal, m_cash});
        end
        @(negedge clock);
        drive(6'd0);
        if (inj) begin
            ib = 6'($urandom) & ~pat;
            if (ib != 6'd0) begin
                drive(ib);
                m_ovr = 1'b1;
            end
        end
        @(negedge clock);
        drive(6'd0);
        #1;
        wait_drain("req");
        if (settle) begin
            @(negedge clock); #1;
            chk("idle_busy", busy, 0);
            chk("idle_balance", balance, m_bal);
            chk("idle_cash", cash, m_cash);
            chk("idle_overrun", overrun, m_ovr);
        end
    endtask

    initial begin
        bit d;
        int c, n;
        logic [5:0] p;

        // Withdraw 100k, then deposit 200k
        do_reset();
        do_req(6'b010000, 1'b0, 1'b1, d);
        chk("w100k_balance", balance, 18);
        do_reset();
        do_req(6'b000100, 1'b0, 1'b1, d);
        chk("d200k_cash", cash, 104);

`ifndef ATM_VAULT_LIMIT_EN
        // Drain balance to 3, then an oversize withdrawal is refused
        do_reset();
        repeat (4) do_req(6'b100000, 1'b0, 1'b0, d);
        do_req(6'b001000, 1'b0, 1'b1, d);
        do_req(6'b100000, 1'b0, 1'b1, d);
        chk("drain_denied", d, 1);
        chk("drain_balance", balance, 3);
`else
        do_reset();
        do_req(6'b100000, 1'b0, 1'b0, d);
        chk("limit_first", d, 0);
        do_req(6'b100000, 1'b0, 1'b0, d);
        chk("limit_second", d, 0);
        do_req(6'b001000, 1'b0, 1'b1, d);
        chk("limit_third_denied", d, 1);
        chk("limit_balance", balance, 12);
`endif

        // Simultaneous W50k and D50k: withdrawal wins, overrun sticks
        do_reset();
        do_req(6'b001001, 1'b0, 1'b1, d);
        do_req(6'b000010, 1'b0, 1'b1, d);
        chk("overrun_sticky", overrun, 1);

        // Reset after the second dispense of a W200k
        do_reset();
        @(negedge clock);
        c = cyc;
        drive(6'b100000);
        q.push_back('{0, c + 2, 16, 96});
        q.push_back('{0, c + 4, 16, 96});
        @(negedge clock);
        drive(6'd0);
        #1;
        wait_drain("mid_reset");
        do_reset();
        repeat (8) @(negedge clock);
        chk("post_reset_balance", balance, 20);

        // Cash overflow boundary via repeated deposits
        n = 0; d = 1'b0;
        while (!d && n < 1100) begin
            do_req(6'b000100, 1'b0, 1'b0, d);
            n++;
        end
        chk("overflow_denied", d, 1);
        chk("overflow_cash", cash, 4092);
        do_req(6'b000001, 1'b0, 1'b1, d);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) != 0) p = 6'd1 << $urandom_range(0, 5);
            else p = (6'd1 << $urandom_range(0, 5)) | (6'd1 << $urandom_range(0, 5));
            do_req(p, ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), d);
            if ($urandom_range(0, 30) == 0) do_reset();
        end
        repeat (4) @(negedge clock);
        chk("final_pending", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
